// File: rtl/sseg_pkg.sv
// Shared constants, register map and FSM state type for the
// seven-segment refresh controller.
package sseg_pkg;

  localparam logic [1:0] ADDR_HEX   = 2'd0;
  localparam logic [1:0] ADDR_POINT = 2'd1;
  localparam logic [1:0] ADDR_LE    = 2'd2;
  localparam logic [1:0] ADDR_BLINK = 2'd3;

  localparam int unsigned BLINK_EN_BIT = 8;
  localparam logic [7:0]  LE_RESET     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    START  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Blank mask seen by the driver: static blanks plus blinking digits in the off phase.
  function automatic logic [7:0] blink_le(input logic [7:0] le,
                                          input logic [7:0] bmask,
                                          input logic       ben,
                                          input logic       phase);
    return le | ({8{ben & phase}} & bmask);
  endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Enabled modulo-DIV divider; tick_o is high for the one enabled cycle in
// which the count sits at its terminal value, and the count wraps to zero.
module sseg_tick_gen #(
  parameter int unsigned DIV   = 2,
  parameter int unsigned CNT_W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sseg_refresh_ctrl.sv
// Register front-end and refresh scheduler for the serial seven-segment
// driver: shadows bus writes, commits them between transfers, adds refresh/blink.
//
// state  | meaning
// IDLE   | waiting for dirty shadows or a pending refresh
// COMMIT | display registers just latched from shadows (visible this cycle)
// START  | one-cycle start pulse to the driver
// HOLD   | outputs frozen while the driver shifts
module sseg_refresh_ctrl #(
  parameter int unsigned REFRESH_DIV = 1000000,
  parameter int unsigned HOLD_CYCLES = 160,
  parameter int unsigned BLINK_DIV   = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] hexs,
  output logic [7:0]  points,
  output logic [7:0]  LEs,
  output logic        start,
  output logic        busy
);

  import sseg_pkg::*;

  localparam int unsigned TMR_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV) + 1;
  localparam int unsigned HLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HLD_W-1:0] HOLD_LAST = HLD_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [HLD_W-1:0] hold_q, hold_d;
  logic             load;

  logic [31:0] sh_hex_q, sh_hex_d;
  logic [7:0]  sh_pt_q, sh_pt_d;
  logic [7:0]  sh_le_q, sh_le_d;
  logic [7:0]  sh_bmask_q, sh_bmask_d;
  logic        sh_ben_q, sh_ben_d;

  logic        dirty_q, dirty_d;
  logic        pending_q, pending_d;
  logic        phase_q, phase_d;

  logic [31:0] hexs_q, hexs_d;
  logic [7:0]  points_q, points_d;
  logic [7:0]  les_q, les_d;

  logic        refresh_tick;
  logic        blink_tick;

  sseg_tick_gen #(
    .DIV   (REFRESH_DIV),
    .CNT_W (TMR_W)
  ) u_refresh_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .tick_o (refresh_tick)
  );

  sseg_tick_gen #(
    .DIV   (BLINK_DIV),
    .CNT_W (BLK_W)
  ) u_blink_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (refresh_tick),
    .tick_o (blink_tick)
  );

  always_comb begin
    sh_hex_d   = sh_hex_q;
    sh_pt_d    = sh_pt_q;
    sh_le_d    = sh_le_q;
    sh_bmask_d = sh_bmask_q;
    sh_ben_d   = sh_ben_q;
    if (we) begin
      case (addr)
        ADDR_HEX:   sh_hex_d = wdata;
        ADDR_POINT: sh_pt_d  = wdata[7:0];
        ADDR_LE:    sh_le_d  = wdata[7:0];
        ADDR_BLINK: begin
          sh_bmask_d = wdata[7:0];
          sh_ben_d   = wdata[BLINK_EN_BIT];
        end
        default: ;
      endcase
    end
  end

  // The display registers latch on the edge into COMMIT, so new data is
  // visible one cycle before start; a write or tick on that same edge
  // re-arms its flag instead of being lost.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dirty_q || pending_q) begin
          load    = 1'b1;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = START;
      end
      START: begin
        state_d = HOLD;
        hold_d  = '0;
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    dirty_d   = we | (dirty_q & ~load);
    pending_d = refresh_tick | blink_tick | (pending_q & ~load);
    phase_d   = phase_q ^ blink_tick;
    hexs_d    = hexs_q;
    points_d  = points_q;
    les_d     = les_q;
    if (load) begin
      hexs_d   = sh_hex_q;
      points_d = sh_pt_q;
      les_d    = blink_le(sh_le_q, sh_bmask_q, sh_ben_q, phase_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      sh_hex_q   <= '0;
      sh_pt_q    <= '0;
      sh_le_q    <= LE_RESET;
      sh_bmask_q <= '0;
      sh_ben_q   <= 1'b0;
      dirty_q    <= 1'b1;
      pending_q  <= 1'b0;
      phase_q    <= 1'b0;
      hexs_q     <= '0;
      points_q   <= '0;
      les_q      <= LE_RESET;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      sh_hex_q   <= sh_hex_d;
      sh_pt_q    <= sh_pt_d;
      sh_le_q    <= sh_le_d;
      sh_bmask_q <= sh_bmask_d;
      sh_ben_q   <= sh_ben_d;
      dirty_q    <= dirty_d;
      pending_q  <= pending_d;
      phase_q    <= phase_d;
      hexs_q     <= hexs_d;
      points_q   <= points_d;
      les_q      <= les_d;
    end
  end

  assign hexs   = hexs_q;
  assign points = points_q;
  assign LEs    = les_q;
  assign start  = (state_q == START);
  assign busy   = (state_q != IDLE);

endmodule
